// File: rtl/time_set_sequencer.sv
// ----------------------------------------------------------------------------
// time_set_sequencer
//   Keypad-driven editor for the clock's time and date registers. SET freezes
//   the counters and walks hour, minute, second, day, month and year. Each
//   field takes two BCD digits. The value is range-checked, then written to
//   the counter datapath with a one-cycle load strobe.
//
// Ports
//   clk_i        system clock, rising edge
//   rst_i        asynchronous reset, active high
//   key_valid_i  1-cycle strobe qualifying key_code_i
//   key_code_i   0-9 digit, 10 SET, 11 ENTER (skip), 12 CANCEL, 13-15 ignored
//   clk_hold_o   freezes the time/date counters while editing
//   field_sel_o  field being edited (0 hr, 1 min, 2 sec, 3 day, 4 mon, 5 yr)
//   digit_buf_o  BCD entry in progress {tens, ones}
//   ld_strobe_o  1-cycle write enable toward the counter datapath
//   ld_field_o   target field of the last load (held between strobes)
//   ld_value_o   BCD value of the last load (held between strobes)
//   err_o        1-cycle pulse: entered value out of range
//   tmo_o        1-cycle pulse: edit abandoned after TIMEOUT_CYC idle cycles
// ----------------------------------------------------------------------------
module time_set_sequencer #(
    parameter int unsigned TIMEOUT_CYC = 1000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       key_valid_i,
    input  logic [3:0] key_code_i,
    output logic       clk_hold_o,
    output logic [2:0] field_sel_o,
    output logic [7:0] digit_buf_o,
    output logic       ld_strobe_o,
    output logic [2:0] ld_field_o,
    output logic [7:0] ld_value_o,
    output logic       err_o,
    output logic       tmo_o
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC);

    localparam logic [3:0] KEY_SET    = 4'd10;
    localparam logic [3:0] KEY_ENTER  = 4'd11;
    localparam logic [3:0] KEY_CANCEL = 4'd12;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TENS,
        S_ONES,
        S_CHECK,
        S_LOAD
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      field_q, field_d;
    logic [7:0]      digit_q, digit_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic            hold_q, hold_d;
    logic            ld_strobe_q, ld_strobe_d;
    logic [2:0]      ld_field_q, ld_field_d;
    logic [7:0]      ld_value_q, ld_value_d;
    logic            err_q, err_d;
    logic            tmo_q, tmo_d;

    logic            is_digit;
    logic [6:0]      value;
    logic            in_range;
    logic            do_skip;
    logic            do_idle;

    assign is_digit = (key_code_i <= 4'd9);

    // Digits are always 0-9, so the binary conversion never exceeds 99.
    assign value = 7'(digit_q[7:4]) * 7'd10 + 7'(digit_q[3:0]);

    always_comb begin
        in_range = 1'b1;
        case (field_q)
            3'd0:       in_range = (value <= 7'd23);
            3'd1, 3'd2: in_range = (value <= 7'd59);
            3'd3:       in_range = (value >= 7'd1) && (value <= 7'd31);
            3'd4:       in_range = (value >= 7'd1) && (value <= 7'd12);
            default:    in_range = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        field_d     = field_q;
        digit_d     = digit_q;
        timer_d     = timer_q;
        ld_strobe_d = 1'b0;
        ld_field_d  = ld_field_q;
        ld_value_d  = ld_value_q;
        err_d       = 1'b0;
        tmo_d       = 1'b0;
        do_skip     = 1'b0;
        do_idle     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (key_valid_i && key_code_i == KEY_SET) begin
                    state_d = S_TENS;
                    field_d = '0;
                    digit_d = '0;
                    timer_d = '0;
                end
            end
            S_TENS, S_ONES: begin
                // An accepted key beats a timeout expiring on the same edge;
                // ignored keys (SET, 13-15) let the timer keep running.
                if (key_valid_i && is_digit) begin
                    timer_d = '0;
                    if (state_q == S_TENS) begin
                        digit_d[7:4] = key_code_i;
                        state_d      = S_ONES;
                    end else begin
                        digit_d[3:0] = key_code_i;
                        state_d      = S_CHECK;
                    end
                end else if (key_valid_i && key_code_i == KEY_ENTER) begin
                    do_skip = 1'b1;
                end else if (key_valid_i && key_code_i == KEY_CANCEL) begin
                    do_idle = 1'b1;
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    do_idle = 1'b1;
                    tmo_d   = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_CHECK: begin
                if (in_range) begin
                    state_d = S_LOAD;
                end else begin
                    err_d   = 1'b1;
                    digit_d = '0;
                    timer_d = '0;
                    state_d = S_TENS;
                end
            end
            S_LOAD: begin
                ld_strobe_d = 1'b1;
                ld_field_d  = field_q;
                ld_value_d  = digit_q;
                do_skip     = 1'b1;
            end
            default: begin
                do_idle = 1'b1;
            end
        endcase

        if (do_skip) begin
            if (field_q < 3'd5) begin
                field_d = field_q + 3'd1;
                digit_d = '0;
                timer_d = '0;
                state_d = S_TENS;
            end else begin
                do_idle = 1'b1;
            end
        end

        if (do_idle) begin
            state_d = S_IDLE;
            field_d = '0;
            digit_d = '0;
            timer_d = '0;
        end

        hold_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            field_q     <= '0;
            digit_q     <= '0;
            timer_q     <= '0;
            hold_q      <= 1'b0;
            ld_strobe_q <= 1'b0;
            ld_field_q  <= '0;
            ld_value_q  <= '0;
            err_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            field_q     <= field_d;
            digit_q     <= digit_d;
            timer_q     <= timer_d;
            hold_q      <= hold_d;
            ld_strobe_q <= ld_strobe_d;
            ld_field_q  <= ld_field_d;
            ld_value_q  <= ld_value_d;
            err_q       <= err_d;
            tmo_q       <= tmo_d;
        end
    end

    assign clk_hold_o  = hold_q;
    assign field_sel_o = field_q;
    assign digit_buf_o = digit_q;
    assign ld_strobe_o = ld_strobe_q;
    assign ld_field_o  = ld_field_q;
    assign ld_value_o  = ld_value_q;
    assign err_o       = err_q;
    assign tmo_o       = tmo_q;

endmodule
